// File: rtl/seq_bit_serializer.sv
// seq_bit_serializer: FIFO-buffered parallel-to-serial bit stream source feeding the sequence detectors
module seq_bit_serializer #(
  parameter int DATA_W = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int CLKS_PER_BIT = 1,
  parameter bit MSB_FIRST = 1,
  parameter bit IDLE_BIT = 0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          en,
  input  logic [DATA_W-1:0]             s_data,
  input  logic                          s_valid,
  output logic                          s_ready,
  output logic                          ser_out,
  output logic                          ser_valid,
  output logic                          frame_start,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = $clog2(DATA_W);
  localparam int HW = CLKS_PER_BIT > 1 ? $clog2(CLKS_PER_BIT) : 1;
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t state, state_n;
  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [DATA_W-1:0] shreg, shreg_n, head;
  logic [BW-1:0] bit_idx, bit_idx_n;
  logic [HW-1:0] hold_cnt, hold_cnt_n;
  logic ser_out_n, ser_valid_n, frame_start_n, busy_n;
  logic push, pop, last_hold, word_done, load;
  assign s_ready = fifo_count != CW'(FIFO_DEPTH);
  assign push = s_valid && s_ready;
  assign head = mem[rd_ptr];
  assign last_hold = hold_cnt == HW'(CLKS_PER_BIT - 1);
  assign word_done = state == IDLE || (en && last_hold && bit_idx == BW'(DATA_W - 1));
  assign load = en && fifo_count != '0 && word_done;
  always_comb begin
    state_n = state;
    shreg_n = shreg;
    bit_idx_n = bit_idx;
    hold_cnt_n = hold_cnt;
    ser_out_n = ser_out;
    ser_valid_n = 1'b0;
    frame_start_n = 1'b0;
    busy_n = busy;
    pop = 1'b0;
    if (load) begin
      pop = 1'b1;
      state_n = SHIFT;
      shreg_n = head;
      bit_idx_n = '0;
      hold_cnt_n = '0;
      ser_out_n = MSB_FIRST ? head[DATA_W-1] : head[0];
      ser_valid_n = 1'b1;
      frame_start_n = 1'b1;
      busy_n = 1'b1;
    end else if (word_done) begin
      state_n = IDLE;
      ser_out_n = IDLE_BIT;
      busy_n = 1'b0;
    end else if (en) begin
      ser_valid_n = 1'b1;
      hold_cnt_n = last_hold ? '0 : hold_cnt + HW'(1);
      bit_idx_n = last_hold ? bit_idx + BW'(1) : bit_idx;
      shreg_n = last_hold ? (MSB_FIRST ? shreg << 1 : shreg >> 1) : shreg;
      ser_out_n = last_hold ? (MSB_FIRST ? shreg[DATA_W-2] : shreg[1]) : ser_out;
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= s_data;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      wr_ptr <= '0;
      rd_ptr <= '0;
      fifo_count <= '0;
      shreg <= '0;
      bit_idx <= '0;
      hold_cnt <= '0;
      ser_out <= IDLE_BIT;
      ser_valid <= 1'b0;
      frame_start <= 1'b0;
      busy <= 1'b0;
    end else begin
      state <= state_n;
      wr_ptr <= push ? wr_ptr + AW'(1) : wr_ptr;
      rd_ptr <= pop ? rd_ptr + AW'(1) : rd_ptr;
      fifo_count <= fifo_count + CW'(push) - CW'(pop);
      shreg <= shreg_n;
      bit_idx <= bit_idx_n;
      hold_cnt <= hold_cnt_n;
      ser_out <= ser_out_n;
      ser_valid <= ser_valid_n;
      frame_start <= frame_start_n;
      busy <= busy_n;
    end
  end
endmodule

// File: tb/tb_seq_bit_serializer.sv
// tb_seq_bit_serializer: checks two serializers (1 and 3 clocks per bit) against a word/bit-level model
module tb_seq_bit_serializer;
  localparam int DW = 8;
  localparam int D = 4;
  logic clk = 0, rst, en, s_valid, chk = 0;
  logic [DW-1:0] s_data;
  logic rdy [2], so [2], sv [2], fs [2], bz [2];
  logic [2:0] fc [2];
  int pass_n = 0, total_n = 0, cyc = 0;
  logic [DW-1:0] mf [2][D];
  logic [DW-1:0] mw [2];
  int mh [2], msz [2], mk [2], mheld [2];
  bit m_out [2], m_val [2], m_fs [2], m_busy [2];
  int cpb;
  bit push_m, load_m;
  logic [63:0] cap [2];
  int n [2], nfs [2], paused [2], first [2], last [2];
  always #5 clk = ~clk;
  seq_bit_serializer #(.DATA_W(DW), .FIFO_DEPTH(D), .CLKS_PER_BIT(1), .MSB_FIRST(1), .IDLE_BIT(0)) dut1 (
    .clk(clk), .rst(rst), .en(en), .s_data(s_data), .s_valid(s_valid), .s_ready(rdy[0]),
    .ser_out(so[0]), .ser_valid(sv[0]), .frame_start(fs[0]), .busy(bz[0]), .fifo_count(fc[0]));
  seq_bit_serializer #(.DATA_W(DW), .FIFO_DEPTH(D), .CLKS_PER_BIT(3), .MSB_FIRST(1), .IDLE_BIT(0)) dut3 (
    .clk(clk), .rst(rst), .en(en), .s_data(s_data), .s_valid(s_valid), .s_ready(rdy[1]),
    .ser_out(so[1]), .ser_valid(sv[1]), .frame_start(fs[1]), .busy(bz[1]), .fifo_count(fc[1]));
  task automatic check(input string nm, input int i, input longint act, input longint exp);
    total_n++;
    if (act == exp) pass_n++;
    else $display("FAIL %s dut%0d: got %0h expected %0h", nm, i, act, exp);
  endtask
  task automatic tick;
    @(posedge clk);
    #2;
  endtask
  task automatic clr;
    for (int i = 0; i < 2; i++) begin
      cap[i] = '0;
      n[i] = 0;
      nfs[i] = 0;
      paused[i] = 0;
      first[i] = 0;
      last[i] = 0;
    end
  endtask
  always @(posedge clk)
    for (int i = 0; i < 2; i++) begin
      cpb = i == 0 ? 1 : 3;
      push_m = s_valid && msz[i] < D;
      if (rst) begin
        msz[i] = 0;
        mh[i] = 0;
        m_out[i] = 0;
        m_val[i] = 0;
        m_fs[i] = 0;
        m_busy[i] = 0;
      end else begin
        m_fs[i] = 0;
        load_m = !m_busy[i];
        if (m_busy[i] && !en) m_val[i] = 0;
        else if (m_busy[i]) begin
          m_val[i] = 1;
          mheld[i]++;
          if (mheld[i] == cpb) begin
            mheld[i] = 0;
            mk[i]++;
            if (mk[i] == DW) load_m = 1;
            else m_out[i] = mw[i][DW-1-mk[i]];
          end
        end
        if (load_m && en && msz[i] > 0) begin
          mw[i] = mf[i][mh[i]];
          mh[i] = (mh[i] + 1) % D;
          msz[i]--;
          mk[i] = 0;
          mheld[i] = 0;
          m_out[i] = mw[i][DW-1];
          m_val[i] = 1;
          m_fs[i] = 1;
          m_busy[i] = 1;
        end else if (load_m) begin
          m_out[i] = 0;
          m_val[i] = 0;
          m_busy[i] = 0;
        end
        if (push_m) begin
          mf[i][(mh[i] + msz[i]) % D] = s_data;
          msz[i]++;
        end
      end
    end
  always @(negedge clk) begin
    cyc++;
    if (chk)
      for (int i = 0; i < 2; i++) begin
        check("ser_out", i, so[i], m_out[i]);
        check("ser_valid", i, sv[i], m_val[i]);
        check("frame_start", i, fs[i], m_fs[i]);
        check("busy", i, bz[i], m_busy[i]);
        check("fifo_count", i, fc[i], msz[i]);
        check("s_ready", i, rdy[i], msz[i] < D);
        if (sv[i]) begin
          cap[i] = {cap[i][62:0], so[i]};
          if (fs[i]) nfs[i]++;
          if (n[i] == 0) first[i] = cyc;
          last[i] = cyc;
          n[i]++;
        end
        if (bz[i] && !sv[i]) paused[i]++;
      end
  end
  initial begin
    rst = 1;
    en = 1;
    s_valid = 1;
    s_data = 8'h55;
    tick;
    chk = 1;
    tick;
    tick;
    check("rst_no_take", 0, fc[0], 0);
    rst = 0;
    s_valid = 0;
    tick;
    check("rst_ser_out", 0, so[0], 0);
    check("rst_ser_valid", 0, sv[0], 0);
    check("rst_count", 0, fc[0], 0);
    check("rst_ready", 0, rdy[0], 1);
    clr;
    s_data = 8'hB6;
    s_valid = 1;
    tick;
    s_valid = 0;
    repeat (30) tick;
    check("single_bits", 0, n[0], 8);
    check("single_word", 0, cap[0][7:0], 8'hB6);
    check("single_fs", 0, nfs[0], 1);
    check("single_idle", 0, so[0], 0);
    check("single_bits", 1, n[1], 24);
    check("single_word", 1, cap[1][23:0], 24'hE3F1F8);
    clr;
    s_valid = 1;
    s_data = 8'hFF;
    tick;
    s_data = 8'h00;
    tick;
    s_data = 8'hA5;
    tick;
    s_valid = 0;
    repeat (80) tick;
    check("b2b_bits", 0, n[0], 24);
    check("b2b_words", 0, cap[0][23:0], 24'hFF00A5);
    check("b2b_fs", 0, nfs[0], 3);
    check("b2b_span", 0, last[0] - first[0] + 1, 24);
    check("b2b_bits", 1, n[1], 72);
    check("b2b_span", 1, last[1] - first[1] + 1, 72);
    check("b2b_fs", 1, nfs[1], 3);
    clr;
    en = 0;
    s_valid = 1;
    for (int k = 1; k <= 4; k++) begin
      s_data = 8'(k * 8'h11);
      tick;
    end
    check("full_ready", 0, rdy[0], 0);
    check("full_ready", 1, rdy[1], 0);
    check("full_count", 0, fc[0], 4);
    s_data = 8'h55;
    tick;
    check("full_reject", 0, fc[0], 4);
    check("full_reject", 1, fc[1], 4);
    s_valid = 0;
    en = 1;
    repeat (110) tick;
    check("drain_bits", 0, n[0], 32);
    check("drain_words", 0, cap[0][31:0], 32'h11223344);
    check("drain_bits", 1, n[1], 96);
    check("drain_fs", 1, nfs[1], 4);
    check("drain_empty", 1, fc[1], 0);
    clr;
    s_data = 8'h81;
    s_valid = 1;
    tick;
    s_valid = 0;
    repeat (8) tick;
    en = 0;
    tick;
    tick;
    en = 1;
    repeat (30) tick;
    check("pause_bits", 1, n[1], 24);
    check("pause_word", 1, cap[1][23:0], 24'hE00007);
    check("pause_cycles", 1, paused[1], 2);
    check("pause_bits", 0, n[0], 8);
    check("pause_word", 0, cap[0][7:0], 8'h81);
    check("pause_cycles", 0, paused[0], 2);
    clr;
    s_valid = 1;
    s_data = 8'h0F;
    tick;
    s_data = 8'h3C;
    tick;
    s_data = 8'h99;
    tick;
    s_valid = 0;
    repeat (3) tick;
    check("mid_bit4", 0, so[0], 1);
    check("mid_queued", 0, fc[0], 2);
    rst = 1;
    tick;
    check("mid_rst_out", 0, so[0], 0);
    check("mid_rst_valid", 0, sv[0], 0);
    check("mid_rst_count", 0, fc[0], 0);
    check("mid_rst_count", 1, fc[1], 0);
    rst = 0;
    clr;
    repeat (40) tick;
    check("mid_no_bits", 0, n[0], 0);
    check("mid_no_bits", 1, n[1], 0);
    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end
endmodule

// File: doc/seq_bit_serializer.md
Name: seq_bit_serializer

Overview:
- Upstream stimulus stage for the sequence-detector FSM top level.
- Accepts parallel words over a valid/ready handshake and buffers them in a small FIFO.
- Shifts each word out one bit at a time on a single serial line; that line drives the detectors' serial `in` input.
- Gives the Moore, Mealy and gate-level detectors a gap-free, deterministic bit stream at a programmable bit rate.

Parameters:
- DATA_W, 8, word width in bits (2..32).
- FIFO_DEPTH, 4, input FIFO depth in words (power of 2, 2..16).
- CLKS_PER_BIT, 1, clock cycles each serial bit is held (1..255).
- MSB_FIRST, 1, 1 = bit DATA_W-1 is sent first; 0 = bit 0 is sent first.
- IDLE_BIT, 0, level driven on ser_out when no word is being sent.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  synchronous reset, active-high.
- en  input  1  shift enable; 0 freezes the serializer (the FIFO still accepts words).
- s_data  input  DATA_W  parallel word in.
- s_valid  input  1  s_data is valid.
- s_ready  output  1  FIFO can accept a word.
- ser_out  output  1  serial bit to the detector `in`.
- ser_valid  output  1  ser_out carries a frame bit this cycle.
- frame_start  output  1  one-cycle pulse on the first cycle of each word's first bit.
- busy  output  1  a word is being shifted.
- fifo_count  output  $clog2(FIFO_DEPTH)+1  words currently held in the FIFO.

Behaviour:
- Reset values: s_ready=1, ser_out=IDLE_BIT, ser_valid=0, frame_start=0, busy=0, fifo_count=0.
- Reset mid-operation discards the FIFO contents and any in-flight word. The first cycle after rst deasserts shows the reset values.
- FIFO:
  - A push occurs when s_valid && s_ready.
  - s_ready = (fifo_count != FIFO_DEPTH), combinational from registered state.
  - A push into a full FIFO is not accepted, even if a pop happens in the same cycle.
  - Push and pop in the same cycle leave fifo_count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
  - FIFO order is strict first-in, first-out.
- FSM has two states, IDLE and SHIFT. The registered outputs ser_out, ser_valid, frame_start and busy are updated on the same edge as the state.
- IDLE:
  - ser_out=IDLE_BIT, ser_valid=0, busy=0.
  - If en && fifo_count>0: pop the head word into the shift register, bit_idx=0, hold_cnt=0, go to SHIFT.
  - On that edge: ser_out = first bit, ser_valid=1, frame_start=1, busy=1.
- SHIFT, with en=1:
  - hold_cnt increments each cycle.
  - When hold_cnt == CLKS_PER_BIT-1: hold_cnt=0 and advance to the next bit.
  - frame_start is high only on the first cycle of bit 0.
- SHIFT, with en=0:
  - hold_cnt, bit_idx and ser_out are frozen.
  - ser_valid=0 and frame_start=0 while paused.
  - Resuming restores ser_valid=1. The remaining hold time continues from the frozen count.
- End of a word: after the last bit's final hold cycle:
  - If en && fifo_count>0: pop the next word. Its first bit follows on the next cycle with no idle gap, and frame_start pulses.
  - Otherwise return to IDLE.
- Latency, CLKS_PER_BIT=1, en=1, FIFO empty, accepted handshake at edge T:
  - fifo_count=1 after edge T.
  - First bit appears on ser_out after edge T+1.
  - The last bit is held through edge T+DATA_W.
  - ser_out=IDLE_BIT after edge T+DATA_W+1.
- A word occupies exactly DATA_W*CLKS_PER_BIT ser_valid cycles.
- fifo_count reflects pushes and pops registered on each edge.
- en has no effect on the FIFO.

Test Plan:
- Reset: rst=1 for 3 cycles with s_valid=1 → after the deassert edge, ser_out=0, ser_valid=0, fifo_count=0, s_ready=1. No word is taken during reset.
- Single word: MSB_FIRST=1, CLKS_PER_BIT=1, push 8'hB6 → ser_out sequence 1,0,1,1,0,1,1,0. Exactly 8 cycles of ser_valid=1, one frame_start on the first bit, then ser_out=0.
- Back-to-back: push 8'hFF, 8'h00, 8'hA5 in consecutive cycles → 24 contiguous ser_valid cycles, frame_start at cycles 0/8/16, bits in FIFO order.
- Full FIFO: hold en=0 and push 5 words with FIFO_DEPTH=4 → s_ready=0 after the 4th push, the 5th word is not accepted, fifo_count=4. Raising en drains the 4 words in order.
- Bit rate and pause: CLKS_PER_BIT=3, push 8'h81, drop en for 2 cycles in the middle of the 3rd bit → every bit held 3 ser_valid cycles, ser_out steady during the pause, 24 ser_valid cycles total.
- Reset mid-word and detector hookup:
  - rst while bit 4 of a word is being sent, with 2 words queued → ser_out=0, fifo_count=0 next cycle, and no queued bits are emitted later.
  - Separately, drive top_digital `in` from ser_out with the pattern containing the target sequence → the detector outputs pulse at the cycles predicted by the reference model.
